seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Reader side of the 7-segment display interface. It samples an external segment bus (a..g plus dp) and waits for the pattern to settle. It then decodes the settled pattern back to a hex digit and reports each new stable pattern with a one-cycle valid pulse.
- Used for loopback self-test of the seg7 encoder path and for reading another board's display.
- Lives alongside the synchronizer/debouncer blocks and reuses their two-flop synchronization approach.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted; legal range 2..15.
- ACTIVE_LOW, 0, 1 = segment inputs are active-low (common anode); inverted after synchronization.

Ports:
- clk, input, 1, single system clock.
- rst, input, 1, asynchronous active-high reset.
- seg_in, input, 7, raw segment lines, bit0=a .. bit6=g; asynchronous to clk.
- dp_in, input, 1, raw decimal-point line; same polarity as seg_in.
- clr_err, input, 1, synchronous clear of err_sticky.
- digit_out, output, 4, decoded hex value of last accepted pattern.
- dp_out, output, 1, decimal point of last accepted pattern.
- blank_out, output, 1, last accepted pattern had all seven segments off.
- invalid_out, output, 1, last accepted pattern is neither blank nor one of the 16 table entries.
- valid, output, 1, one-cycle pulse on each accepted new pattern.
- err_sticky, output, 1, set by any invalid acceptance.
- event_cnt, output, 8, count of valid pulses.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0.
  - Synchronizer flops, candidate register, stability counter and accepted-pattern register are all 0.
  - The accepted_seen flag is 0.
- Input path:
  - The 8-bit bus {dp_in, seg_in} passes through a two-flop synchronizer (s1, s2).
  - If ACTIVE_LOW=1, s2 is inverted before any further use.
- Stability counter (width 4):
  - If the synchronized sample differs from the candidate register, the candidate loads the sample and the counter loads 1.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- Accept condition, evaluated each cycle:
  - The counter equals STABLE_CYCLES-1 and the sample equals the candidate, so the counter reaches STABLE_CYCLES this edge.
  - And either accepted_seen=0 or the candidate differs from the accepted pattern. The dp bit participates in this comparison.
- On accept, registered at that edge:
  - The accepted pattern updates and accepted_seen is set.
  - valid is high for exactly one cycle.
  - digit_out, dp_out, blank_out and invalid_out update in the same cycle as valid and hold until the next accept.
- Latency: a clean input change set up before edge E0 produces valid high after edge E0+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges total. With STABLE_CYCLES=4 this is edge E0+5. The bench checks this exactly.
- Decode table, segment code {g..a} -> digit:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
  - 00 -> blank_out=1, digit_out=0, invalid_out=0.
  - Any other code -> invalid_out=1, digit_out=0, blank_out=0.
- Glitch handling:
  - Any change shorter than STABLE_CYCLES samples produces no valid.
  - If the bus returns to the accepted pattern after a glitch, no valid is produced.
- Repetition: a pattern held indefinitely produces exactly one valid. The counter stays saturated.
- First pattern after reset: it is reported even if blank (00), once stable.
- event_cnt: increments on each valid and wraps 255->0.
- err_sticky:
  - Set on an accept with invalid decode; cleared when clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all state clears immediately. The next stable pattern is reported as the first pattern.

Test Plan:
- After reset, seg_in=0x3F, dp_in=0 held, STABLE_CYCLES=4 -> valid pulses once, 5 edges after the change; digit_out=0, event_cnt=1; no further valid over 50 cycles.
- Step through all 16 table codes, each held 10 cycles -> 16 valid pulses; digit_out=0..F in order; event_cnt=16; invalid_out and blank_out stay 0.
- Hold 0x06, then 3-cycle glitch to 0x7F, then back to 0x06 -> no valid for the glitch or the return.
- Hold 0x6D with dp_in=0, then dp_in=1 -> second valid; digit_out=5, dp_out=1.
- Apply 0x49 (invalid) -> valid with invalid_out=1 and err_sticky=1. Assert clr_err in the same cycle as a second invalid accept -> err_sticky stays 1. clr_err alone -> err_sticky=0.
- ACTIVE_LOW=1, seg_in=~0x4F -> digit_out=3. Assert rst mid-count -> outputs 0 immediately. Apply 0x00 stable -> valid with blank_out=1 and event_cnt=1. Run 256 accepts -> event_cnt wraps to 0.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Segment-bus capture interface: raw display lines in, decoded digit/status out.
// Latency: none, signal bundle only.
// Backpressure: none; the valid output is a fire-and-forget pulse.
interface seg7_capture_if;
  logic [6:0] seg_in;
  logic       dp_in;
  logic       clr_err;
  logic [3:0] digit_out;
  logic       dp_out;
  logic       blank_out;
  logic       invalid_out;
  logic       valid;
  logic       err_sticky;
  logic [7:0] event_cnt;

  // Side that drives the display lines and consumes the decoded result
  modport master (
    output seg_in, dp_in, clr_err,
    input  digit_out, dp_out, blank_out, invalid_out, valid, err_sticky, event_cnt
  );

  // Capture block side
  modport slave (
    input  seg_in, dp_in, clr_err,
    output digit_out, dp_out, blank_out, invalid_out, valid, err_sticky, event_cnt
  );
endinterface

// File: rtl/seg7_capture.sv
// Samples an async 7-segment bus, waits for it to settle, decodes it to a hex digit.
// Latency: STABLE_CYCLES+2 edges from a clean input change to the valid pulse.
// Backpressure: none; each accepted pattern is reported with a single-cycle valid.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input logic           clk,
  input logic           rst,
  seg7_capture_if.slave bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] samp;
  logic [7:0] cand;
  logic [7:0] acc;
  logic [3:0] cnt;
  logic       seen;
  logic       accept;

  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_invalid;

  logic [3:0] digit_q;
  logic       dp_q;
  logic       blank_q;
  logic       invalid_q;
  logic       valid_q;
  logic       err_q;
  logic [7:0] event_q;

  // Polarity is normalised after synchronisation so everything downstream is active-high.
  assign samp = ACTIVE_LOW ? ~s2 : s2;

  // Counter sits one short of saturation and the sample still matches: this edge
  // completes the stable run. The dp bit is part of the pattern identity.
  assign accept = (cnt == STABLE - 4'd1) && (samp == cand) && (!seen || (cand != acc));

  // Two-flop synchroniser on the whole {dp, a..g} bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {bus.dp_in, bus.seg_in};
      s2 <= s1;
    end
  end

  // Track the current candidate and how many consecutive cycles it has been seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (samp != cand) begin
      cand <= samp;
      cnt  <= 4'd1;
    end else if (cnt < STABLE) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Decode the candidate segment code {g..a}; decoded fields are latched only on accept
  always_comb begin
    dec_digit   = 4'h0;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (cand[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  // Record the accepted pattern and publish its decode alongside the valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      seen      <= 1'b0;
      valid_q   <= 1'b0;
      digit_q   <= '0;
      dp_q      <= 1'b0;
      blank_q   <= 1'b0;
      invalid_q <= 1'b0;
      event_q   <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        acc       <= cand;
        seen      <= 1'b1;
        digit_q   <= dec_digit;
        dp_q      <= cand[7];
        blank_q   <= dec_blank;
        invalid_q <= dec_invalid;
        event_q   <= event_q + 8'd1;
      end
    end
  end

  // Sticky error: a new invalid acceptance takes priority over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && dec_invalid) begin
      err_q <= 1'b1;
    end else if (bus.clr_err) begin
      err_q <= 1'b0;
    end
  end

  assign bus.digit_out   = digit_q;
  assign bus.dp_out      = dp_q;
  assign bus.blank_out   = blank_q;
  assign bus.invalid_out = invalid_q;
  assign bus.valid       = valid_q;
  assign bus.err_sticky  = err_q;
  assign bus.event_cnt   = event_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: active-high and active-low instances.
// Latency: checks the exact valid timing after a clean input change.
// Backpressure: not applicable; valid pulses are counted on the falling edge.
module tb_seg7_capture;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_capture_if bus0 ();
  seg7_capture_if bus1 ();

  seg7_capture #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seg7_capture #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int vectors    = 0;
  int miscompares = 0;
  int vcnt0      = 0;

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Count valid pulses on dut0 away from the active edge
  always @(negedge clk) begin
    if (bus0.valid === 1'b1) vcnt0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus0.seg_in  = 7'h00;
    bus0.dp_in   = 1'b0;
    bus0.clr_err = 1'b0;
    bus1.seg_in  = ~7'h4F;
    bus1.dp_in   = 1'b1;
    bus1.clr_err = 1'b0;
    step(2);

    // Reset state
    chk("rst_digit",   32'(bus0.digit_out),   32'h0);
    chk("rst_valid",   32'(bus0.valid),       32'h0);
    chk("rst_evcnt",   32'(bus0.event_cnt),   32'h0);
    chk("rst_err",     32'(bus0.err_sticky),  32'h0);
    chk("rst_blank",   32'(bus0.blank_out),   32'h0);
    chk("rst_invalid", 32'(bus0.invalid_out), 32'h0);
    chk("rst_dp",      32'(bus0.dp_out),      32'h0);

    // First pattern: valid exactly after the 6th edge (E0+5)
    rst         = 1'b0;
    bus0.seg_in = 7'h3F;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("lat_e%0d", k), 32'(bus0.valid), (k == 5) ? 32'h1 : 32'h0);
    end
    chk("first_digit", 32'(bus0.digit_out), 32'h0);
    chk("first_evcnt", 32'(bus0.event_cnt), 32'h1);
    step(50);
    chk("hold_one_valid", 32'(vcnt0), 32'd1);

    // Active-low instance saw ~0x4F from reset release
    chk("al_digit",   32'(bus1.digit_out),   32'h3);
    chk("al_invalid", 32'(bus1.invalid_out), 32'h0);
    chk("al_dp",      32'(bus1.dp_out),      32'h0);
    chk("al_evcnt",   32'(bus1.event_cnt),   32'h1);

    // Blank pattern, then every table entry in order
    bus0.seg_in = 7'h00;
    step(10);
    chk("blank_out", 32'(bus0.blank_out), 32'h1);
    chk("blank_digit", 32'(bus0.digit_out), 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus0.seg_in = codes[i];
      step(10);
      chk($sformatf("tbl_digit_%0d", i), 32'(bus0.digit_out), 32'(i));
      chk($sformatf("tbl_inv_%0d", i), 32'(bus0.invalid_out), 32'h0);
      chk($sformatf("tbl_blank_%0d", i), 32'(bus0.blank_out), 32'h0);
    end
    chk("tbl_evcnt", 32'(bus0.event_cnt), 32'd18);
    chk("tbl_vcnt",  32'(vcnt0), 32'd18);

    // Short glitch and return to the accepted pattern produce nothing
    bus0.seg_in = 7'h06;
    step(10);
    chk("pre_glitch_vcnt", 32'(vcnt0), 32'd19);
    bus0.seg_in = 7'h7F;
    step(3);
    bus0.seg_in = 7'h06;
    step(20);
    chk("glitch_vcnt",  32'(vcnt0), 32'd19);
    chk("glitch_digit", 32'(bus0.digit_out), 32'h1);

    // dp alone distinguishes patterns
    bus0.seg_in = 7'h6D;
    step(10);
    chk("dp0_digit", 32'(bus0.digit_out), 32'h5);
    chk("dp0_dp",    32'(bus0.dp_out), 32'h0);
    bus0.dp_in = 1'b1;
    step(10);
    chk("dp1_digit", 32'(bus0.digit_out), 32'h5);
    chk("dp1_dp",    32'(bus0.dp_out), 32'h1);
    chk("dp1_evcnt", 32'(bus0.event_cnt), 32'd21);

    // Invalid code sets the sticky error
    bus0.dp_in  = 1'b0;
    bus0.seg_in = 7'h49;
    step(10);
    chk("inv_flag",  32'(bus0.invalid_out), 32'h1);
    chk("inv_err",   32'(bus0.err_sticky), 32'h1);
    chk("inv_digit", 32'(bus0.digit_out), 32'h0);
    chk("inv_evcnt", 32'(bus0.event_cnt), 32'd22);

    // Clear coincident with a second invalid accept: set wins
    bus0.dp_in = 1'b1;
    step(5);
    bus0.clr_err = 1'b1;
    step(1);
    bus0.clr_err = 1'b0;
    chk("setwin_valid", 32'(bus0.valid), 32'h1);
    chk("setwin_err",   32'(bus0.err_sticky), 32'h1);
    bus0.clr_err = 1'b1;
    step(1);
    bus0.clr_err = 1'b0;
    chk("clr_err",      32'(bus0.err_sticky), 32'h0);
    chk("clr_inv_hold", 32'(bus0.invalid_out), 32'h1);
    chk("clr_evcnt",    32'(bus0.event_cnt), 32'd23);

    // Reset in the middle of a count clears everything at once
    bus0.dp_in  = 1'b0;
    bus0.seg_in = 7'h5B;
    step(3);
    rst = 1'b1;
    #1;
    chk("mid_rst_evcnt",   32'(bus0.event_cnt), 32'h0);
    chk("mid_rst_invalid", 32'(bus0.invalid_out), 32'h0);
    chk("mid_rst_dp",      32'(bus0.dp_out), 32'h0);
    chk("mid_rst_valid",   32'(bus0.valid), 32'h0);
    bus0.seg_in = 7'h00;
    step(2);
    rst = 1'b0;
    step(10);
    chk("post_rst_blank", 32'(bus0.blank_out), 32'h1);
    chk("post_rst_evcnt", 32'(bus0.event_cnt), 32'h1);
    chk("post_rst_vcnt",  32'(vcnt0), 32'd24);

    // 255 further accepts wrap the event counter through 255 to 0
    for (int i = 0; i < 254; i++) begin
      bus0.seg_in = (i % 2 == 0) ? 7'h06 : 7'h5B;
      step(8);
    end
    chk("wrap_255", 32'(bus0.event_cnt), 32'd255);
    bus0.seg_in = 7'h06;
    step(8);
    chk("wrap_0",    32'(bus0.event_cnt), 32'd0);
    chk("wrap_vcnt", 32'(vcnt0), 32'd279);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
